// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder:
// FSM state encoding and default operand width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// Full adder built from two half adders;
// the two partial carries can never both be set.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .i_a (a),
    .i_b (b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  half_adder u_ha1 (
    .i_a (w_s0),
    .i_b (ci),
    .o_s (s),
    .o_c (w_c1)
  );

  assign co = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder primitive:
// sum is the XOR, carry is the AND of the inputs.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one bit per clock,
// start/busy/done handshake, registered result.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_load;
  logic             w_step;
  logic             w_fin;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_acc_nx;

  full_adder_cell u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  // Accumulator after this cycle's bit enters at the MSB.
  always_comb begin
    w_acc_nx = r_acc >> 1;
    w_acc_nx[WIDTH-1] = w_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and datapath controls.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_fin  = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand/accumulator shifters, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_acc <= '0;
      r_c   <= cin;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_acc <= w_acc_nx;
      r_c   <= w_co;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers update only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_fin) begin
      r_sum  <= w_acc_nx;
      r_cout <= w_co;
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder
// at WIDTH=8, plus random sums at WIDTH=13 and WIDTH=1.
module tb_bit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        cin = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  sum;
  logic        cout;

  logic        s13 = 1'b0;
  logic [12:0] a13 = '0;
  logic [12:0] b13 = '0;
  logic        c13 = 1'b0;
  logic        busy13;
  logic        done13;
  logic [12:0] sum13;
  logic        cout13;

  logic        s1 = 1'b0;
  logic [0:0]  a1 = '0;
  logic [0:0]  b1 = '0;
  logic        c1 = 1'b0;
  logic        busy1;
  logic        done1;
  logic [0:0]  sum1;
  logic        cout1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .a_in (a_in), .b_in (b_in), .cin (cin),
    .busy (busy), .done (done), .sum (sum), .cout (cout)
  );

  bit_serial_adder #(.WIDTH(13)) dut13 (
    .clk (clk), .rst_n (rst_n), .start (s13),
    .a_in (a13), .b_in (b13), .cin (c13),
    .busy (busy13), .done (done13), .sum (sum13), .cout (cout13)
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .start (s1),
    .a_in (a1), .b_in (b1), .cin (c1),
    .busy (busy1), .done (done1), .sum (sum1), .cout (cout1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Waits at negedges for done; counts busy cycles seen.
  task automatic wait_done(output int nb, output bit ok);
    nb = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  // Issues one add; returns at the negedge where done is high.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b,
                        input logic c, output int nb, output bit ok);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = ~a; b_in = ~b; cin = ~c;
    wait_done(nb, ok);
  endtask

  initial begin
    int nb;
    int nd;
    bit ok;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [8:0]  e9;
    logic [13:0] e14;

    // 1: reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'h00);
    chk("rst_cout", 32'(cout), 32'd0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("idle_no_done", 32'(nd), 32'd0);

    // 2: basic add
    do_add(8'h5A, 8'h33, 1'b0, nb, ok);
    chk("t2_ok",   32'(ok),   32'd1);
    chk("t2_busy", 32'(nb),   32'd8);
    chk("t2_sum",  32'(sum),  32'h8D);
    chk("t2_cout", 32'(cout), 32'd0);
    @(negedge clk);
    chk("t2_pulse", 32'(done), 32'd0);

    // 3: wrap-around
    do_add(8'hFF, 8'h01, 1'b0, nb, ok);
    chk("t3a_sum",  32'(sum),  32'h00);
    chk("t3a_cout", 32'(cout), 32'd1);
    do_add(8'hFF, 8'hFF, 1'b1, nb, ok);
    chk("t3b_sum",  32'(sum),  32'hFF);
    chk("t3b_cout", 32'(cout), 32'd1);

    // 4: start during RUN ignored
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_busy3", 32'(busy), 32'd1);
    a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, ok);
    chk("t4_ok",   32'(ok),   32'd1);
    chk("t4_sum",  32'(sum),  32'h30);
    chk("t4_cout", 32'(cout), 32'd0);
    nd = 1;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t4_one_done", 32'(nd), 32'd1);

    // 5: back-to-back via start held through DONE
    do_add(8'h12, 8'h34, 1'b0, nb, ok);
    chk("t5_first", 32'(sum), 32'h46);
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_hold", 32'(sum),  32'h46);
    wait_done(nb, ok);
    chk("t5_ok",    32'(ok),   32'd1);
    chk("t5_nbusy", 32'(nb),   32'd8);
    chk("t5_sum",   32'(sum),  32'h02);
    chk("t5_cout",  32'(cout), 32'd0);

    // 6: abort mid-RUN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_sum",  32'(sum),  32'h00);
    chk("t6_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("t6_quiet", 32'(nd), 32'd0);
    chk("t6_sum2",  32'(sum), 32'h00);

    // Random, WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      do_add(ra, rb, rc, nb, ok);
      chk("rnd8", 32'({cout, sum}), 32'(e9));
    end

    // Random, WIDTH=13
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      a13 = 13'($urandom); b13 = 13'($urandom);
      c13 = 1'($urandom); s13 = 1'b1;
      e14 = {1'b0, a13} + {1'b0, b13} + {13'd0, c13};
      @(negedge clk);
      s13 = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (done13) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      chk("rnd13_ok", 32'(ok), 32'd1);
      chk("rnd13", 32'({cout13, sum13}), 32'(e14));
    end

    // Random, WIDTH=1
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a1 = 1'($urandom); b1 = 1'($urandom);
      c1 = 1'($urandom); s1 = 1'b1;
      @(negedge clk);
      s1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      chk("w1_done", 32'(done1), 32'd1);
      chk("rnd1", 32'({cout1, sum1}),
          32'(a1) + 32'(b1) + 32'(c1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
